// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - sequencing FSM for the shift-add multiplier datapath
// Accepts operands, steps the datapath WIDTH_M times, then holds the product until consumed.
module mult_controller #(
  parameter int WIDTH_M = 16,
  parameter int WIDTH_C = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  input  logic multiplier_lsb,
  input  logic count_check,
  input  logic empty,
  output logic load_words,
  output logic flush,
  output logic add_shift,
  output logic shift,
  output logic ready,
  output logic busy,
  output logic protocol_err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH_C-1:0] LAST_STEP = WIDTH_C'(WIDTH_M - 1);

  state_t             state, state_next;
  logic [WIDTH_C-1:0] step, step_next;
  logic               err_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      step         <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_next;
      step  <= step_next;
      if (err_set) protocol_err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    err_set    = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ready      = 1'b0;
    load_words = 1'b0;
    flush      = 1'b0;
    add_shift  = 1'b0;
    shift      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_words = 1'b1;
          flush      = 1'b1;
          step_next  = '0;
          // A zero operand needs no steps: the flush already produced the answer.
          state_next = empty ? DONE : CALC;
        end
      end
      CALC: begin
        add_shift = multiplier_lsb;
        shift     = ~multiplier_lsb;
        step_next = step + 1'b1;
        if (step == LAST_STEP) begin
          err_set    = ~count_check;
          state_next = DONE;
          step_next  = '0;
        end else if (count_check) begin
          // Datapath counter reached its end early; abandon the multiply.
          err_set    = 1'b1;
          state_next = DONE;
          step_next  = '0;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        ready     = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
